// File: rtl/ps2_key_event_rx_pkg.sv
// Shared types and constants for the PS/2 key-event receiver.
package ps2_pkg;

    // Set-2 prefix bytes folded into the following key code
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK
    } ps2_state_t;

    // One decoded key event as stored in the FIFO
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    // Frame is LSB-first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    // Odd parity: the data bits and the parity bit together hold an odd number of ones.
    function automatic logic frame_ok(input logic [10:0] frame);
        return ~frame[0] & frame[10] & (^frame[9:1]);
    endfunction

endpackage

// File: rtl/ps2_key_event_rx_if.sv
// Key-event stream: show-ahead valid/ready plus FIFO occupancy.
interface ps2_key_event_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    import ps2_pkg::*;

    logic                          evt_valid;
    logic                          evt_ready;
    logic [7:0]                    evt_code;
    logic                          evt_ext;
    logic                          evt_break;
    logic [$clog2(FIFO_DEPTH):0]   evt_count;

    modport master (
        output evt_valid, evt_code, evt_ext, evt_break, evt_count,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_code, evt_ext, evt_break, evt_count,
        output evt_ready
    );

endinterface

// File: rtl/ps2_key_event_rx_fifo.sv
// Generic show-ahead FIFO; the head entry is readable while not empty.
// Occupancy is counted separately so full/empty never alias.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-2 depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame capture,
// E0/F0 prefix folding and a buffered key-event stream.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps2c,
    input  logic                  ps2d,
    input  logic                  rx_en,
    ps2_key_event_rx_if.master    evt,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [1:0]            c_sync_reg, d_sync_reg;
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  f_c_reg, f_c_next, fall;
    ps2_state_t            state_reg, state_next;
    logic [3:0]            bit_cnt_reg;
    logic [10:0]           shift_reg;
    logic [TW-1:0]         tmo_reg;
    logic                  tmo_hit;
    logic                  ext_reg, brk_reg, tmo_err_reg;
    logic                  check_err, tmo_abort, set_ext, set_brk, push_req, clr_flags;
    logic [7:0]            rx_byte;
    ps2_evt_t              push_evt, head_evt;
    logic                  fifo_full, fifo_empty, pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Two-flop synchronisers and the clock-line glitch filter shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_reg <= '0;
            d_sync_reg <= '0;
            filt_reg   <= '0;
            f_c_reg    <= 1'b0;
        end else begin
            c_sync_reg <= {c_sync_reg[0], ps2c};
            d_sync_reg <= {d_sync_reg[0], ps2d};
            filt_reg   <= {filt_reg[FILTER_LEN-2:0], c_sync_reg[1]};
            f_c_reg    <= f_c_next;
        end
    end

    // Filtered clock changes only on a unanimous window; a falling edge is one sample wide
    always_comb begin
        f_c_next = f_c_reg;
        if (&filt_reg)       f_c_next = 1'b1;
        else if (~|filt_reg) f_c_next = 1'b0;
    end
    assign fall    = f_c_reg & ~f_c_next;
    assign tmo_hit = (tmo_reg == TW'(TIMEOUT_CYC - 1));
    assign rx_byte = shift_reg[8:1];

    // Frame FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Frame FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (fall && rx_en) state_next = ST_DATA;
            ST_DATA: begin
                if (fall) begin
                    if (bit_cnt_reg == 4'd1) state_next = ST_CHECK;
                end else if (tmo_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Frame FSM outputs: validity check and prefix decoding in CHECK, abort on timeout
    always_comb begin
        check_err = 1'b0;
        set_ext   = 1'b0;
        set_brk   = 1'b0;
        push_req  = 1'b0;
        tmo_abort = 1'b0;
        if (state_reg == ST_CHECK) begin
            if (!frame_ok(shift_reg))           check_err = 1'b1;
            else if (rx_byte == PS2_PREFIX_EXT) set_ext   = 1'b1;
            else if (rx_byte == PS2_PREFIX_BRK) set_brk   = 1'b1;
            else                                push_req  = 1'b1;
        end
        if (state_reg == ST_DATA && !fall && tmo_hit) tmo_abort = 1'b1;
        clr_flags = check_err | tmo_abort | push_req;
    end

    // Frame datapath: bit shifter, bit counter, inter-edge timeout and prefix flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tmo_reg     <= '0;
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            tmo_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && fall && rx_en) begin
                shift_reg   <= {d_sync_reg[1], shift_reg[10:1]};
                bit_cnt_reg <= 4'd10;
                tmo_reg     <= '0;
            end else if (state_reg == ST_DATA) begin
                if (fall) begin
                    shift_reg   <= {d_sync_reg[1], shift_reg[10:1]};
                    bit_cnt_reg <= bit_cnt_reg - 4'd1;
                    tmo_reg     <= '0;
                end else begin
                    tmo_reg <= tmo_reg + TW'(1);
                end
            end
            if (clr_flags)    ext_reg <= 1'b0;
            else if (set_ext) ext_reg <= 1'b1;
            if (clr_flags)    brk_reg <= 1'b0;
            else if (set_brk) brk_reg <= 1'b1;
            tmo_err_reg <= tmo_abort;
        end
    end

    assign push_evt  = '{code: rx_byte, ext: ext_reg, brk: brk_reg};
    assign pop       = evt.evt_ready & ~fifo_empty;
    assign frame_err = check_err | tmo_err_reg;
    assign overflow  = push_req & fifo_full & ~pop;

    ps2_evt_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (push_evt),
        .pop   (pop),
        .dout  (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head entry is masked to zero while empty so outputs are clean after reset
    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_code  = fifo_empty ? 8'h00 : head_evt.code;
    assign evt.evt_ext   = ~fifo_empty & head_evt.ext;
    assign evt.evt_break = ~fifo_empty & head_evt.brk;
    assign evt.evt_count = fifo_count;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx with hand-computed frames and events.
module tb_ps2_key_event_rx;

    logic clk = 1'b0;
    logic reset, ps2c, ps2d, rx_en;
    logic frame_err, overflow;
    bit   glitch_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   err_pulses = 0;
    int   ovf_pulses = 0;

    ps2_key_event_rx_if #(.FIFO_DEPTH(4)) evt_bus ();

    ps2_key_event_rx #(
        .FILTER_LEN  (4),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rx_en     (rx_en),
        .evt       (evt_bus.master),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    // {valid, code, ext, brk}
    logic [10:0] head;
    assign head = {evt_bus.evt_valid, evt_bus.evt_code, evt_bus.evt_ext, evt_bus.evt_break};

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (overflow === 1'b1)  ovf_pulses++;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic drive_bit(input logic b);
        ps2d = b;
        repeat (8) @(posedge clk);
        #1 ps2c = 1'b0;
        repeat (16) @(posedge clk);
        #1 ps2c = 1'b1;
        if (glitch_en) begin
            repeat (3) @(posedge clk);
            #1 ps2c = 1'b0;
            @(posedge clk);
            #1 ps2c = 1'b1;
            repeat (4) @(posedge clk);
        end else begin
            repeat (8) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        logic [10:0] f;
        f = frame_bits(d, p);
        for (int i = 0; i < 11; i++) drive_bit(f[i]);
        ps2d = 1'b1;
        $display("frame sent: data=%02h parity=%0b", d, p);
    endtask

    // Sends start..parity, then drops the clock for the stop bit and returns at once
    task automatic send_head(input logic [7:0] d, input logic p);
        logic [10:0] f;
        f = frame_bits(d, p);
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        ps2d = 1'b1;
        repeat (8) @(posedge clk);
        #1 ps2c = 1'b0;
    endtask

    task automatic finish_stop(input logic [7:0] d, input logic p);
        repeat (14) @(posedge clk);
        #1 ps2c = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        $display("frame sent: data=%02h parity=%0b (timed)", d, p);
    endtask

    task automatic pop_one;
        evt_bus.evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_bus.evt_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; evt_bus.evt_ready = 1'b0;
        #2;
        checks++;
        if ({head, evt_bus.evt_count, frame_err, overflow} !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0", {head, evt_bus.evt_count, frame_err, overflow});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if ({head, evt_bus.evt_count, frame_err, overflow} !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h required 0", {head, evt_bus.evt_count, frame_err, overflow});
        end
        $display("reset sequence done");
    endtask

    task automatic test_make_break;
        send_head(8'h2B, 1'b1);
        repeat (6) @(posedge clk);
        #1;  // cycle T: stop-bit fall
        checks++;
        if (evt_bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL mb_valid_T: got %b required 0", evt_bus.evt_valid);
        end
        @(posedge clk); #1;  // T+1
        checks++;
        if ({evt_bus.evt_valid, frame_err} !== 2'b00) begin
            errors++; $display("FAIL mb_T1: valid/err got %b required 00", {evt_bus.evt_valid, frame_err});
        end
        @(posedge clk); #1;  // T+2
        checks++;
        if (head !== {1'b1, 8'h2B, 1'b0, 1'b0} || evt_bus.evt_count !== 3'd1) begin
            errors++; $display("FAIL mb_T2: head %h count %0d required %h count 1", head, evt_bus.evt_count, {1'b1, 8'h2B, 2'b00});
        end
        finish_stop(8'h2B, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h2B, 1'b1);
        checks++;
        if (evt_bus.evt_count !== 3'd2) begin
            errors++; $display("FAIL mb_count: got %0d required 2", evt_bus.evt_count);
        end
        pop_one();
        checks++;
        if (head !== {1'b1, 8'h2B, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mb_break_evt: got %h required %h", head, {1'b1, 8'h2B, 2'b01});
        end
        pop_one();
        checks++;
        if (evt_bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL mb_empty: valid got %b required 0", evt_bus.evt_valid);
        end
    endtask

    task automatic test_ext_break;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b1);
        checks++;
        if (evt_bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL eb_prefix_only: valid got %b required 0", evt_bus.evt_valid);
        end
        send_frame(8'h75, 1'b0);
        checks++;
        if (head !== {1'b1, 8'h75, 1'b1, 1'b1} || evt_bus.evt_count !== 3'd1) begin
            errors++; $display("FAIL eb_event: head %h count %0d required %h count 1", head, evt_bus.evt_count, {1'b1, 8'h75, 2'b11});
        end
        pop_one();
    endtask

    task automatic test_parity_err;
        int e0;
        send_frame(8'hF0, 1'b1);  // pending break prefix must be cleared by the error
        e0 = err_pulses;
        send_head(8'h2B, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL pe_err_T: got %b required 0", frame_err);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL pe_err_T1: got %b required 1", frame_err);
        end
        @(posedge clk); #1;
        checks++;
        if ({evt_bus.evt_valid, frame_err} !== 2'b00) begin
            errors++; $display("FAIL pe_T2: valid/err got %b required 00", {evt_bus.evt_valid, frame_err});
        end
        finish_stop(8'h2B, 1'b0);
        checks++;
        if (err_pulses - e0 !== 1) begin
            errors++; $display("FAIL pe_pulses: got %0d required 1", err_pulses - e0);
        end
        send_frame(8'h33, 1'b1);
        checks++;
        if (head !== {1'b1, 8'h33, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pe_next: got %h required %h", head, {1'b1, 8'h33, 2'b00});
        end
        pop_one();
    endtask

    task automatic test_timeout;
        int e0;
        logic [10:0] f;
        e0 = err_pulses;
        f = frame_bits(8'h2B, 1'b1);
        for (int i = 0; i < 5; i++) drive_bit(f[i]);
        ps2d = 1'b1;
        $display("partial frame sent: 5 bits");
        checks++;
        if (err_pulses - e0 !== 0) begin
            errors++; $display("FAIL to_early: pulses got %0d required 0", err_pulses - e0);
        end
        repeat (250) @(posedge clk);
        #1;
        checks++;
        if (err_pulses - e0 !== 1 || evt_bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL to_abort: pulses %0d valid %b required 1 and 0", err_pulses - e0, evt_bus.evt_valid);
        end
        send_frame(8'h1C, 1'b0);
        checks++;
        if (head !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++; $display("FAIL to_next: got %h required %h", head, {1'b1, 8'h1C, 2'b00});
        end
        pop_one();
    endtask

    task automatic test_glitch;
        int e0;
        e0 = err_pulses;
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(posedge clk);
            #1 ps2c = 1'b0;
            @(posedge clk);
            #1 ps2c = 1'b1;
        end
        repeat (250) @(posedge clk);
        #1;
        checks++;
        if (err_pulses - e0 !== 0 || evt_bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL gl_idle: pulses %0d valid %b required 0 and 0", err_pulses - e0, evt_bus.evt_valid);
        end
        glitch_en = 1'b1;
        send_frame(8'h33, 1'b1);
        glitch_en = 1'b0;
        checks++;
        if (head !== {1'b1, 8'h33, 1'b0, 1'b0} || evt_bus.evt_count !== 3'd1) begin
            errors++; $display("FAIL gl_frame: head %h count %0d required %h count 1", head, evt_bus.evt_count, {1'b1, 8'h33, 2'b00});
        end
        pop_one();
    endtask

    task automatic test_rx_disable;
        int e0;
        e0 = err_pulses;
        rx_en = 1'b0;
        send_frame(8'h2B, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (evt_bus.evt_valid !== 1'b0 || evt_bus.evt_count !== 3'd0 || err_pulses - e0 !== 0) begin
            errors++; $display("FAIL rx_disabled: valid %b count %0d pulses %0d required 0 0 0", evt_bus.evt_valid, evt_bus.evt_count, err_pulses - e0);
        end
        rx_en = 1'b1;
    endtask

    task automatic test_back_to_back;
        int o0;
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        o0 = ovf_pulses;
        for (int i = 0; i < 5; i++) send_frame(codes[i], ~^codes[i]);
        checks++;
        if (evt_bus.evt_count !== 3'd4 || ovf_pulses - o0 !== 1) begin
            errors++; $display("FAIL ov_fill: count %0d ovf %0d required 4 and 1", evt_bus.evt_count, ovf_pulses - o0);
        end
        checks++;
        if (head !== {1'b1, 8'h15, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ov_head0: got %h required %h", head, {1'b1, 8'h15, 2'b00});
        end
        evt_bus.evt_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (head !== {1'b1, codes[k], 1'b0, 1'b0} || evt_bus.evt_count !== 3'(4 - k)) begin
                errors++; $display("FAIL ov_pop%0d: head %h count %0d required %h count %0d", k, head, evt_bus.evt_count, {1'b1, codes[k], 2'b00}, 4 - k);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (evt_bus.evt_valid !== 1'b0 || evt_bus.evt_count !== 3'd0) begin
            errors++; $display("FAIL ov_drain: valid %b count %0d required 0 0", evt_bus.evt_valid, evt_bus.evt_count);
        end
        evt_bus.evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int e0;
        logic [10:0] f;
        send_frame(8'h15, 1'b0);
        send_frame(8'h1D, 1'b1);
        f = frame_bits(8'h24, 1'b1);
        for (int i = 0; i < 4; i++) drive_bit(f[i]);
        ps2d = 1'b1;
        $display("partial frame sent: 4 bits, asserting reset");
        e0 = err_pulses;
        reset = 1'b1;
        #2;
        checks++;
        if ({head, evt_bus.evt_count, frame_err, overflow} !== 16'h0) begin
            errors++; $display("FAIL rm_outputs: got %h required 0", {head, evt_bus.evt_count, frame_err, overflow});
        end
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (err_pulses - e0 !== 0 || evt_bus.evt_valid !== 1'b0) begin
            errors++; $display("FAIL rm_quiet: pulses %0d valid %b required 0 0", err_pulses - e0, evt_bus.evt_valid);
        end
        send_frame(8'h2B, 1'b1);
        checks++;
        if (head !== {1'b1, 8'h2B, 1'b0, 1'b0} || evt_bus.evt_count !== 3'd1) begin
            errors++; $display("FAIL rm_next: head %h count %0d required %h count 1", head, evt_bus.evt_count, {1'b1, 8'h2B, 2'b00});
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_ext_break();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_rx_disable();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver and scan-code decoder. It samples the PS/2 clock and data lines and deserialises 11-bit frames, checking start, stop and odd parity. It folds the Set-2 prefixes E0 (extended) and F0 (break) into single key events and buffers those events in a show-ahead FIFO with a valid/ready handshake. It sits between the keyboard pins and the RTC controller's command logic, and replaces the earlier single-byte receiver with its ad-hoc combinational F0 latch.

## Interface
Parameters:
- FILTER_LEN, 8: ps2c glitch-filter length in clk samples (≥2).
- FIFO_DEPTH, 8: event FIFO entries; must be a power of 2 and ≥2.
- TIMEOUT_CYC, 200000: idle clk cycles allowed between falling edges inside a frame (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ps2c  in  1  raw PS/2 clock pin.
- ps2d  in  1  raw PS/2 data pin.
- rx_en  in  1  permits start of a new frame.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event was E0-prefixed.
- evt_break  out  1  head event is a release (F0-prefixed).
- evt_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Reset values: all outputs 0. Internal state: FSM in IDLE, prefix flags cleared, FIFO empty.

## Operation
- **Input conditioning:** ps2c and ps2d each pass through a 2-flop synchroniser.
  - Synchronised ps2c shifts into a FILTER_LEN-bit register.
  - Filtered clock f_c goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds.
  - fall = f_c_reg & ~f_c_next.
- **Frame FSM states:** IDLE, DATA, CHECK.
  - IDLE: on fall & rx_en, shift in ps2d, set bit counter to 10, clear the timeout counter, go to DATA. A fall while rx_en=0 is ignored.
  - DATA: on each fall, shift ps2d into an 11-bit LSB-first register and decrement the counter. When the fall arrives with counter 1, go to CHECK.
  - DATA timeout: the timeout counter resets on every fall. Reaching TIMEOUT_CYC-1 aborts: pulse frame_err, clear prefix flags, go to IDLE.
  - CHECK (1 cycle): the frame is valid iff start=0, stop=1 and XOR(data,parity)=1. An invalid frame pulses frame_err, clears prefix flags and produces no event. Always returns to IDLE.
- **rx_en** is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- **Decoder**, run on each valid byte:
  - E0: set ext.
  - F0: set brk.
  - Any other byte: push {code, ext, brk} and clear both flags.
  - Repeated prefixes are idempotent.
- **FIFO:** show-ahead; evt_* reflect the head entry while evt_valid=1 and are don't-care otherwise.
  - Pop occurs when evt_valid & evt_ready.
  - Push is accepted when count<FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow pulses.
  - Pointers wrap modulo FIFO_DEPTH. Count is tracked separately so that full and empty are unambiguous.
- **Reset mid-frame:** the partial frame is discarded, no error pulses, and the FIFO is emptied.

## Timing
- Let T be the clk cycle in which fall is high for the stop bit.
  - FSM is in CHECK during T+1.
  - The FIFO write commits at the end of T+1.
  - evt_valid=1 and the new evt_count are visible in T+2 when the FIFO was empty.
- frame_err is high during T+1 for parity, start or stop errors.
- On timeout, frame_err is high in the cycle after the counter reaches TIMEOUT_CYC-1.
- A pop updates evt_* and evt_count in the next cycle. Back-to-back pops at one per cycle are supported.
- Pin-to-fall latency is 2 synchroniser cycles plus FILTER_LEN cycles.
- An event that requires a prefix completes only on its final byte; prefix bytes alone generate no output.

## Structure
- Package ps2_pkg:
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - Frame-FSM state enum.
  - Event record (code[7:0], ext, brk; 10 bits) as a packed typedef.
- Sub-module ps2_evt_fifo: generic show-ahead synchronous FIFO, parameters WIDTH=10 and DEPTH=FIFO_DEPTH, ports push/pop/full/empty/count.
- Filter, FSM and decoder stay in the top module.

## Test plan
- Frame 0x2B (parity 1), then F0 (parity 1), then 2B → two events in order:
  - {2B, ext=0, brk=0};
  - {2B, ext=0, brk=1}.
  - evt_valid rises at T+2 of the first frame.
- Sequence E0, F0, 75 (parities 0, 1, 0) → one event {75, ext=1, brk=1}, and no event for the prefixes.
- Frame 0x2B with parity bit 0 → frame_err pulses once at T+1 and no event is produced. A following valid 0x33 yields {33,0,0} with no stale prefix.
- Stop after 5 bits, then wait TIMEOUT_CYC cycles → frame_err pulses and the FSM returns to IDLE. A following valid frame decodes correctly.
- FIFO_DEPTH=4, evt_ready=0, 5 valid make codes:
  - 4 are stored, evt_count=4, overflow pulses on the 5th;
  - then hold evt_ready=1 → 4 pops on consecutive cycles in arrival order, and evt_valid drops.
- 1-sample glitches on ps2c produce no fall.
- With rx_en=0, a full frame is ignored.
- Reset asserted mid-frame and mid-FIFO → all outputs 0, and the next frame decodes normally.
